b2r_converter_h: RTL and testbench
==================================

// Module: b2r_converter_h
// PURPOSE
//  Block-to-row converter; the inverse of the horizontal row-to-block slicer on the systolic-array output side.
//  Accepts 2x2 output blocks in column-group-major order (row-block index inner).
//  Buffers the full ROW x COL matrix, then streams it back as row-major rows of COL elements.
//  Sits between the multi-MAC result collector and the next layer's row-major input buffer.
// PARAMETERS
//  WIDTH       16   element width (fixed-point, passed through untouched)
//  FRAC_WIDTH  8    fraction bits; informational only, no arithmetic
//  ROW         256  matrix rows; must be a multiple of BLOCK_SIZE
//  COL         64   matrix columns; must be a multiple of BLOCK_SIZE
//  BLOCK_SIZE  2    block edge; only 2 is supported (block layout is fixed)
// PORTS
//  clk           in   1                    clock, all logic on rising edge
//  rst           in   1                    synchronous reset, active-high
//  en            in   1                    global enable; low = full stall
//  in_valid      in   1                    in_block is valid
//  in_ready      out  1                    block accepted when in_valid & in_ready & en
//  in_block      in   WIDTH*4              2x2 block, MSB-first: {r0c0, r1c0, r0c1, r1c1}
//  out_row       out  WIDTH*COL            row data; column 0 in the MSB slice [WIDTH*COL-1 -: WIDTH]
//  out_valid     out  1                    out_row is valid
//  out_ready     in   1                    row consumed when out_valid & out_ready & en
//  row_last      out  1                    high with out_valid on row ROW-1
//  buffer_done   out  1                    one-cycle pulse after the last row is consumed
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; in_ready, out_valid, row_last, buffer_done = 0; out_row = 0. RAM contents are not cleared.
//  FSM:
//   IDLE -> FILL when en.
//   FILL: in_ready=1. Block counters advance per accepted block: rb (0..ROW/2-1, inner) and cg (0..COL/2-1, outer).
//   FILL -> DRAIN on the cycle after accepting rb=ROW/2-1, cg=COL/2-1.
//   DRAIN -> DONE on the cycle after row ROW-1 is consumed.
//   DONE: buffer_done=1 for exactly one cycle, then IDLE. The next matrix may follow immediately.
//  Storage: COL/2 banks, one per column group. Each bank is DEPTH ROW/2 x 4*WIDTH and holds one whole block per address.
//  Write: an accepted block is written to bank cg at address rb in a single cycle.
//  Read: address k is read from all banks in parallel; the read returns rows 2k and 2k+1.
//   Row 2k   = concat over cg ascending of {r0c0, r0c1}.
//   Row 2k+1 = concat over cg ascending of {r1c0, r1c1}.
//  Read latency: 1 cycle.
//  Drain timing:
//   First out_valid is at most 2 cycles after entering DRAIN.
//   With out_ready held high, throughput is 1 row/cycle with no bubbles: read k+1 is issued while row 2k is presented.
//  Handshake: while out_valid & !out_ready, out_row and row_last hold stable. There is no loss or duplication for any out_ready pattern.
//  in_ready is 0 outside FILL. Blocks presented in other states are ignored and not stored.
//  en low: all state, counters and registered outputs hold; in_ready=0; no transfer is counted. Resuming continues exactly where it stopped.
//  rst mid-FILL or mid-DRAIN: immediate return to IDLE with reset values. A partial matrix is discarded.
//  Counter widths: $clog2(ROW/2)+1, $clog2(COL/2)+1, $clog2(ROW)+1. Counters wrap to 0 only via the FSM.
// STRUCTURE
//  Shared header converter_defs.vh holds:
//   - FSM state encodings (IDLE/FILL/DRAIN/DONE, 2 bits)
//   - block element index macros (R0C0=3, R1C0=2, R0C1=1, R1C1=0)
//   - the BLOCK_SIZE=2 constant
//  Sub-module ram_1w1r (DATA_WIDTH, DEPTH): one sync-write port, one sync-read port. Instantiated COL/2 times via generate, one per bank.
//  Top level holds the FSM, block counters, the drain pipeline (row-pair register + read prefetch) and output registers.
// TESTING (ROW=4, COL=4, WIDTH=16; element(r,c)=16'h00rc)
//  1. Feed 4 blocks in order (rb0,cg0),(rb1,cg0),(rb0,cg1),(rb1,cg1). First block {0000,0010,0001,0011}; out_ready=1.
//     -> Rows 0..3 on 4 consecutive cycles. Row0 = {0000,0001,0002,0003}. row_last with row 3. buffer_done pulses 1 cycle after.
//  2. Same stimulus with out_ready toggling 1,0,0,1,...
//     -> Exactly 4 transfers, rows in order, out_row stable during stalls.
//  3. in_valid gaps plus en=0 for 3 cycles mid-FILL and mid-DRAIN
//     -> Output identical to test 1, no extra or missing blocks or rows.
//  4. rst asserted after 2 blocks, then a fresh 4-block matrix (element+0x100)
//     -> Only the new matrix is emitted; all outputs 0 the cycle after rst.
//  5. Two matrices back to back
//     -> 8 rows total, buffer_done pulses twice, in_ready=0 during DRAIN.

Source files
------------

// File: rtl/b2r_converter_h_pkg.sv
// Shared definitions for the block-to-row converter: FSM states and the
// fixed 2x2 block element layout.
package b2r_converter_h_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Element slots inside a 4*WIDTH block word, counted from the LSB slice.
    localparam int unsigned R0C0 = 3;
    localparam int unsigned R1C0 = 2;
    localparam int unsigned R0C1 = 1;
    localparam int unsigned R1C1 = 0;

    localparam int unsigned BLK_EDGE = 2;

endpackage

// File: rtl/b2r_converter_h_ram_1w1r.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// whose output holds while re is low.
module ram_1w1r #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/b2r_converter_h.sv
// Block-to-row converter: buffers a ROW x COL matrix arriving as 2x2 blocks
// (row-block inner, column-group outer) and streams it out as row-major rows.
module b2r_converter_h
    import b2r_converter_h_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned ROW        = 256,
    parameter int unsigned COL        = 64,
    parameter int unsigned BLOCK_SIZE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*4-1:0]     in_block,
    output logic [WIDTH*COL-1:0]   out_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   row_last,
    output logic                   buffer_done
);

    localparam int unsigned NRB = ROW / BLK_EDGE;
    localparam int unsigned NCG = COL / BLK_EDGE;
    localparam int unsigned RBW = $clog2(NRB) + 1;
    localparam int unsigned CGW = $clog2(NCG) + 1;
    localparam int unsigned RCW = $clog2(ROW) + 1;
    localparam int unsigned AW  = (NRB > 1) ? $clog2(NRB) : 1;

    if (BLOCK_SIZE != BLK_EDGE || (ROW % BLK_EDGE) != 0 || (COL % BLK_EDGE) != 0
        || FRAC_WIDTH > WIDTH) begin : g_bad_cfg
        $error("b2r_converter_h: unsupported parameter combination");
    end

    state_t           state, state_nxt;
    logic [RBW-1:0]   rb;
    logic [CGW-1:0]   cg;
    logic [RBW-1:0]   rd_addr;
    logic [RCW-1:0]   row_cnt;
    logic             q_valid;
    logic             half;

    logic             accept, fill_last, consume, drain_last, load, rd_en;
    logic [NCG-1:0]   bank_we;
    logic [WIDTH*COL-1:0] even_row, odd_row;

    always_comb begin
        in_ready    = en && (state == ST_FILL);
        buffer_done = en && (state == ST_DONE);
        accept      = in_ready && in_valid;
        fill_last   = accept && (rb == RBW'(NRB - 1)) && (cg == CGW'(NCG - 1));
        consume     = en && out_valid && out_ready;
        drain_last  = consume && (row_cnt == RCW'(ROW - 1));
        load        = en && (state == ST_DRAIN) && q_valid && (!out_valid || out_ready);
        // Next pair is fetched as the odd row of the current pair leaves the read register.
        rd_en       = en && (state == ST_DRAIN) && (rd_addr < RBW'(NRB))
                      && (!q_valid || (load && half));
    end

    for (genvar g = 0; g < NCG; g++) begin : g_bank
        logic [4*WIDTH-1:0] q;

        assign bank_we[g] = accept && (cg == CGW'(g));

        ram_1w1r #(
            .DATA_WIDTH (4*WIDTH),
            .DEPTH      (NRB)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (rb[AW-1:0]),
            .wdata (in_block),
            .re    (rd_en),
            .raddr (rd_addr[AW-1:0]),
            .rdata (q)
        );

        assign even_row[WIDTH*COL-1-2*WIDTH*g -: 2*WIDTH] =
            {q[R0C0*WIDTH +: WIDTH], q[R0C1*WIDTH +: WIDTH]};
        assign odd_row[WIDTH*COL-1-2*WIDTH*g -: 2*WIDTH] =
            {q[R1C0*WIDTH +: WIDTH], q[R1C1*WIDTH +: WIDTH]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en)         state_nxt = ST_FILL;
            ST_FILL:  if (fill_last)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
            ST_DONE:  if (en)         state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb <= '0;
            cg <= '0;
        end else if (accept) begin
            if (rb == RBW'(NRB - 1)) begin
                rb <= '0;
                cg <= (cg == CGW'(NCG - 1)) ? '0 : cg + 1'b1;
            end else begin
                rb <= rb + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            row_cnt   <= '0;
            q_valid   <= 1'b0;
            half      <= 1'b0;
            out_row   <= '0;
            out_valid <= 1'b0;
            row_last  <= 1'b0;
        end else begin
            if (en && state == ST_DONE) begin
                rd_addr <= '0;
                q_valid <= 1'b0;
                half    <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_addr <= rd_addr + 1'b1;
                    q_valid <= 1'b1;
                end else if (load && half) begin
                    q_valid <= 1'b0;
                end
                if (load) begin
                    half <= ~half;
                end
            end

            if (load) begin
                out_row   <= half ? odd_row : even_row;
                out_valid <= 1'b1;
                row_last  <= half && (rd_addr == RBW'(NRB));
            end else if (consume) begin
                out_valid <= 1'b0;
                row_last  <= 1'b0;
            end

            if (consume) begin
                row_cnt <= drain_last ? '0 : row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_b2r_converter_h.sv
// Directed bench for b2r_converter_h at ROW=4, COL=4, WIDTH=16 with
// element(r,c) = 16'h00rc.
module tb_b2r_converter_h;

    localparam int unsigned W = 16;
    localparam int unsigned R = 4;
    localparam int unsigned C = 4;

    // Blocks in arrival order (rb0,cg0),(rb1,cg0),(rb0,cg1),(rb1,cg1).
    localparam logic [63:0] BLK_TBL [4] = '{
        64'h0000_0010_0001_0011,
        64'h0020_0030_0021_0031,
        64'h0002_0012_0003_0013,
        64'h0022_0032_0023_0033
    };
    localparam logic [63:0] ROW_TBL [4] = '{
        64'h0000_0001_0002_0003,
        64'h0010_0011_0012_0013,
        64'h0020_0021_0022_0023,
        64'h0030_0031_0032_0033
    };

    logic             clk = 1'b0;
    logic             rst, en, in_valid, in_ready, out_valid, out_ready;
    logic             row_last, buffer_done;
    logic [4*W-1:0]   in_block;
    logic [W*C-1:0]   out_row;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [63:0] blk_q [$];
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    b2r_converter_h #(
        .WIDTH      (W),
        .FRAC_WIDTH (8),
        .ROW        (R),
        .COL        (C),
        .BLOCK_SIZE (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .row_last    (row_last),
        .buffer_done (buffer_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_matrix(input logic [63:0] off);
        for (int unsigned i = 0; i < 4; i++) begin
            blk_q.push_back(BLK_TBL[i] + off);
            exp_q.push_back({i == 3, ROW_TBL[i] + off});
        end
    endtask

    // rdy_mode 0: out_ready high; 1: out_ready pattern 1,0,0 repeating.
    task automatic run_stream(input int unsigned rdy_mode, input bit gaps,
                              input bit en_holes, input int unsigned n_mat);
        int unsigned cyc = 0, dones = 0, last_acc = 0, last_xfer = 0, nx = 0;
        bit          hold = 1'b0;
        bit          timing = (rdy_mode == 0) && !en_holes;
        logic [63:0] held_row = '0;
        logic        held_last = 1'b0;
        logic [64:0] e;
        while ((exp_q.size() > 0 || dones < n_mat) && cyc < 300) begin
            @(negedge clk);
            en        = !(en_holes && ((cyc >= 4 && cyc <= 6) || (cyc >= 13 && cyc <= 15)));
            out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
            in_valid  = (blk_q.size() > 0) && (!gaps || cyc % 2 == 0);
            in_block  = (blk_q.size() > 0) ? blk_q[0] : '0;
            #1;
            if (hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_row", out_row, held_row);
                check("hold_last", 64'(row_last), 64'(held_last));
            end
            if (!en) check("inrdy_en_low", 64'(in_ready), 64'd0);
            if (out_valid) check("inrdy_drain", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                void'(blk_q.pop_front());
                last_acc = cyc;
            end
            if (out_valid && out_ready && en) begin
                if (exp_q.size() == 0) begin
                    check("extra_row", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", out_row, e[63:0]);
                    check("row_last", 64'(row_last), 64'(e[64]));
                end
                if (timing) begin
                    if (nx % 4 == 0) check("first_lat", 64'(cyc - last_acc), 64'd3);
                    else             check("row_gap", 64'(cyc - last_xfer), 64'd1);
                end
                nx++;
                last_xfer = cyc;
            end
            hold      = out_valid && !(out_ready && en);
            held_row  = out_row;
            held_last = row_last;
            if (buffer_done) begin
                dones++;
                if (timing) check("done_lat", 64'(cyc - last_xfer), 64'd1);
            end
            cyc++;
        end
        check("rows_left", 64'(exp_q.size()), 64'd0);
        check("blocks_left", 64'(blk_q.size()), 64'd0);
        check("done_pulses", 64'(dones), 64'(n_mat));
        @(negedge clk);
        in_valid = 1'b0;
        en       = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_row_last"}, 64'(row_last), 64'd0);
        check({tag, "_done"}, 64'(buffer_done), 64'd0);
        check({tag, "_out_row"}, out_row, 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        #1;
        check_reset_outputs("reset");

        // 1: straight stream
        load_matrix(64'd0);
        run_stream(0, 1'b0, 1'b0, 1);

        // 2: out_ready throttled
        load_matrix(64'd0);
        run_stream(1, 1'b0, 1'b0, 1);

        // 3: input gaps plus enable holes in fill and drain
        load_matrix(64'd0);
        run_stream(0, 1'b1, 1'b1, 1);

        // 4: reset after two blocks, then a fresh offset matrix
        blk_q.push_back(BLK_TBL[0]);
        blk_q.push_back(BLK_TBL[1]);
        for (int i = 0; i < 20 && blk_q.size() > 0; i++) begin
            @(negedge clk);
            en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_block = blk_q[0];
            #1;
            if (in_ready) void'(blk_q.pop_front());
        end
        check("partial_fed", 64'(blk_q.size()), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        load_matrix(64'h0100_0100_0100_0100);
        run_stream(0, 1'b0, 1'b0, 1);

        // 5: two matrices back to back
        load_matrix(64'd0);
        load_matrix(64'h0100_0100_0100_0100);
        run_stream(0, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
